// File: rtl/riscv_pkg.sv
// Shared RISC-V core parameters plus the data-memory arbiter's FSM states and request record.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MEM_SIZE = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } arb_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two data-memory requesters.
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module dmem_arb_pick (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      // The requester that did not win last time gets the slot.
      grant_o = last_grant_i ? 2'b01 : 2'b10;
`else
      grant_o = 2'b01;
`endif
    end
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester valid/ready arbiter in front of a single-port, one-cycle-latency word memory.
// Define DMEM_ARB_RR_EN for round-robin on contention (default: requester 0 fixed priority).
module dmem_arbiter #(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned MEM_SIZE = riscv_pkg::MEM_SIZE,
  localparam int unsigned AW      = $clog2(MEM_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0]           req_we_i,
  input  logic [1:0][XLEN-1:0] req_addr_i,
  input  logic [1:0][XLEN-1:0] req_wdata_i,
  input  logic [1:0][3:0]      req_be_i,
  output logic [1:0]           rsp_valid_o,
  output logic [XLEN-1:0]      rsp_rdata_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  input  logic [XLEN-1:0]      mem_rdata_i,
  output logic                 busy_o
);

  import riscv_pkg::*;

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]      grant;
  logic            last_grant;
  logic            win;
  logic            accept;
  arb_req_t        req_sel;

  dmem_arb_pick u_pick (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant),
    .grant_o      (grant)
  );

  assign accept      = (state_q == IDLE) && (grant != 2'b00);
  assign win         = grant[1];
  assign req_ready_o = (state_q == IDLE) ? grant : 2'b00;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    req_sel.we    = req_we_i[win];
    req_sel.addr  = req_addr_i[win];
    req_sel.wdata = req_wdata_i[win];
    req_sel.be    = req_be_i[win];
  end

  // Only the word index is meaningful; byte offset and high bits wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_sel.addr[XLEN-1:AW+2], req_sel.addr[1:0]};

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = win;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_grant_q <= 1'b1;
    else         last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Memory strobe is registered here so it is high during ISSUE.
          owner_d  = win;
          we_d     = req_sel.we;
          addr_d   = req_sel.addr[AW+1:2];
          be_d     = req_sel.be;
          wdata_d  = req_sel.wdata;
          mem_en_d = 1'b1;
          mem_we_d = req_sel.we;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_rdata_d          = we_q ? '0 : mem_rdata_i;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory plus a word-array reference model.
module tb_dmem_arbiter;
  import riscv_pkg::*;

  localparam int AW = $clog2(MEM_SIZE);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][XLEN-1:0] req_addr, req_wdata;
  logic [1:0][3:0] req_be;
  logic [XLEN-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_be;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN-1:0] ref_mem [MEM_SIZE];
  logic [XLEN-1:0] mem [MEM_SIZE];
  bit mem_init = 1'b0;

  typedef struct packed {
    logic            timeout;
    logic            en1, we1, en2;
    logic [AW-1:0]   addr1;
    logic [3:0]      be1;
    logic [XLEN-1:0] wd1;
    logic            busy1, busy2, busy3;
    logic [1:0]      rv1, rv2, rv3;
    logic [XLEN-1:0] rd3;
  } obs_t;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  function automatic logic [31:0] seed_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Single-port memory with one-cycle read latency and byte-enabled writes.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= seed_word(i);
      mem_init <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % MEM_SIZE);
  endfunction

  task automatic ref_write(input int w, input logic [31:0] wd, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Drives one request and records what the DUT shows in cycles 1..3 after acceptance.
  task automatic run_txn(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output obs_t o);
    int waited = 0;
    o = '0;
    req_valid[r] = 1'b1; req_we[r] = we; req_addr[r] = addr;
    req_wdata[r] = wd;   req_be[r] = be;
    #1;
    while (!req_ready[r] && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    o.timeout = (waited >= 20);
    if (o.timeout) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    o.en1 = mem_en; o.we1 = mem_we; o.addr1 = mem_addr; o.be1 = mem_be;
    o.wd1 = mem_wdata; o.busy1 = busy; o.rv1 = rsp_valid;
    @(posedge clk); #1;
    o.en2 = mem_en; o.busy2 = busy; o.rv2 = rsp_valid;
    @(posedge clk); #1;
    o.rv3 = rsp_valid; o.rd3 = rsp_rdata; o.busy3 = busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({mem_en, mem_we, mem_be, rsp_valid, busy, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got en=%b we=%b be=%h rv=%b busy=%b rdy=%b required all 0",
               mem_en, mem_we, mem_be, rsp_valid, busy, req_ready);
    end
    n_vec++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required 0", mem_addr, mem_wdata, rsp_rdata);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    obs_t o;
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, o);
    n_vec++;
    if (o.timeout !== 1'b0) begin n_err++; $display("FAIL read_accept: got timeout required accept"); end
    n_vec++;
    if ({o.en1, o.we1} !== 2'b10) begin n_err++; $display("FAIL read_strobe: got en/we=%b required 10", {o.en1, o.we1}); end
    n_vec++;
    if (o.addr1 !== AW'(4)) begin n_err++; $display("FAIL read_addr: got %0d required 4", o.addr1); end
    n_vec++;
    if ({o.busy1, o.busy2, o.busy3} !== 3'b110) begin
      n_err++; $display("FAIL read_busy: got %b required 110", {o.busy1, o.busy2, o.busy3});
    end
    n_vec++;
    if ({o.en2, o.rv1, o.rv2, o.rv3} !== 7'b0_00_00_01) begin
      n_err++; $display("FAIL read_timing: got en2=%b rv=%b/%b/%b required 0 00/00/01", o.en2, o.rv1, o.rv2, o.rv3);
    end
    n_vec++;
    if (o.rd3 !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_data: got %h required deadbeef", o.rd3); end
  endtask

  task automatic test_byte_write();
    obs_t o;
    run_txn(1, 1'b1, 32'h20, 32'h0000_00AB, 4'b0001, o);
    ref_write(8, 32'h0000_00AB, 4'b0001);
    n_vec++;
    if ({o.timeout, o.en1, o.we1, o.be1} !== 7'b0_1_1_0001) begin
      n_err++; $display("FAIL wr_strobe: got to/en/we/be=%b/%b/%b/%b required 0/1/1/0001", o.timeout, o.en1, o.we1, o.be1);
    end
    n_vec++;
    if ({o.addr1, o.wd1} !== {AW'(8), 32'h0000_00AB}) begin
      n_err++; $display("FAIL wr_fields: got addr=%0d wd=%h required 8 000000ab", o.addr1, o.wd1);
    end
    n_vec++;
    if ({o.rv3, o.rd3} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL wr_rsp: got rv=%b rd=%h required 10 0", o.rv3, o.rd3);
    end
    run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, o);
    n_vec++;
    if (o.rd3 !== ref_mem[8]) begin n_err++; $display("FAIL wr_readback: got %h required %h", o.rd3, ref_mem[8]); end
  endtask

  task automatic test_contention();
    int grants = 0;
    int rsps = 0;
    logic [1:0] gseq [5];
    logic [1:0] rseq [5];
    logic [1:0] exp_g [5];
    int last = 1;
    bit rr = 1'b0;
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      int w = rr ? (last == 1 ? 0 : 1) : 0;
      exp_g[k] = (w == 1) ? 2'b10 : 2'b01;
      last = w;
    end
    exp_g[4] = 2'b10;
    rstn = 1'b0; #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    req_we = 2'b00; req_addr[0] = 32'h14; req_addr[1] = 32'h18;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 80 && !(grants == 5 && rsps == 5); c++) begin
      if (req_ready != 2'b00) begin
        if (grants < 5) gseq[grants] = req_ready;
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 4) req_valid[0] = 1'b0;
      if (grants >= 5) req_valid[1] = 1'b0;
      if (rsp_valid != 2'b00) begin
        n_vec++;
        if (rsp_rdata !== ref_mem[rsp_valid[1] ? 6 : 5]) begin
          n_err++; $display("FAIL cont_data: got %h required %h", rsp_rdata, ref_mem[rsp_valid[1] ? 6 : 5]);
        end
        if (rsps < 5) rseq[rsps] = rsp_valid;
        rsps++;
      end
    end
    req_valid = 2'b00;
    n_vec++;
    if (grants != 5 || rsps != 5) begin
      n_err++; $display("FAIL cont_count: got grants=%0d rsps=%0d required 5 5", grants, rsps);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (gseq[k] !== exp_g[k] || rseq[k] !== exp_g[k]) begin
          n_err++; $display("FAIL cont_grant%0d: got ready=%b rsp=%b required %b", k, gseq[k], rseq[k], exp_g[k]);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    req_we[0] = 1'b0; req_addr[0] = 32'h24; req_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (req_ready[0] !== (k % 3 == 0)) begin
        n_err++; $display("FAIL b2b_ready%0d: got %b required %b", k, req_ready[0], (k % 3 == 0));
      end
      @(posedge clk); #1;
      n_vec++;
      if (mem_en !== (k % 3 == 0)) begin
        n_err++; $display("FAIL b2b_en%0d: got %b required %b", k + 1, mem_en, (k % 3 == 0));
      end
    end
    req_valid[0] = 1'b0;
    n_vec++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, ref_mem[9]}) begin
      n_err++; $display("FAIL b2b_rsp: got %b %h required 01 %h", rsp_valid, rsp_rdata, ref_mem[9]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'b1100;
    req_valid[0] = 1'b1;
    #1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    ref_write(12, 32'hCAFE_F00D, 4'b1100);
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b required 1", busy); end
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, busy, req_ready} !== '0) begin
      n_err++; $display("FAIL mid_clear: got addr=%h be=%h wd=%h rv=%b busy=%b required all 0",
                        mem_addr, mem_be, mem_wdata, rsp_valid, busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_norsp: got %b required 00", rsp_valid); end
    rstn = 1'b1;
    @(posedge clk); #1;
    run_txn(1, 1'b0, 32'h30, 32'h0, 4'h0, o);
    n_vec++;
    if ({o.timeout, o.rv3, o.rd3} !== {1'b0, 2'b10, ref_mem[12]}) begin
      n_err++; $display("FAIL mid_after: got to=%b rv=%b rd=%h required 0 10 %h", o.timeout, o.rv3, o.rd3, ref_mem[12]);
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    run_txn(0, 1'b0, 32'(MEM_SIZE * 4 + 4), 32'h0, 4'h0, o);
    n_vec++;
    if ({o.addr1, o.rd3} !== {AW'(1), ref_mem[1]}) begin
      n_err++; $display("FAIL wrap: got addr=%0d rd=%h required 1 %h", o.addr1, o.rd3, ref_mem[1]);
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int t = 0; t < 40; t++) begin
      int r = int'($urandom_range(0, 1));
      logic we = 1'($urandom_range(0, 1));
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [3:0] be = 4'($urandom_range(0, 15));
      int w = word_of(addr);
      logic [31:0] exp_rd = we ? 32'h0 : ref_mem[w];
      run_txn(r, we, addr, wd, be, o);
      if (we) ref_write(w, wd, be);
      n_vec++;
      if ({o.timeout, o.en1, o.we1, o.addr1} !== {1'b0, 1'b1, we, AW'(w)}) begin
        n_err++; $display("FAIL rnd%0d_issue: got to=%b en=%b we=%b addr=%0d required 0 1 %b %0d",
                          t, o.timeout, o.en1, o.we1, o.addr1, we, w);
      end
      n_vec++;
      if ({o.rv3, o.rd3} !== {(r == 1) ? 2'b10 : 2'b01, exp_rd}) begin
        n_err++; $display("FAIL rnd%0d_rsp: got rv=%b rd=%h required owner %0d rd=%h", t, o.rv3, o.rd3, r, exp_rd);
      end
      if (we) begin
        n_vec++;
        if ({o.be1, o.wd1} !== {be, wd}) begin
          n_err++; $display("FAIL rnd%0d_wfields: got be=%h wd=%h required %h %h", t, o.be1, o.wd1, be, wd);
        end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = seed_word(i);
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing one single-port, word-organised data memory (MEM_SIZE words of XLEN bits, one-cycle read latency) between the core's load/store port (requester 0) and a debug/loader port (requester 1). It accepts one request at a time over a valid/ready handshake, drives the memory for exactly one cycle, and returns a registered response to the owner. It sits between the core's data-memory port and the dmem array.

## Interface
- XLEN, default 32: data and address width; taken from riscv_pkg.
- MEM_SIZE, default from riscv_pkg: memory depth in words. AW = $clog2(MEM_SIZE).
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester accept; one-hot or zero.
- req_we_i  in  2  per-requester write (1) / read (0).
- req_addr_i  in  2×XLEN  byte address; word index = addr[AW+1:2].
- req_wdata_i  in  2×XLEN  write data.
- req_be_i  in  2×4  byte enables; ignored for reads.
- rsp_valid_o  out  2  one-cycle response pulse to the owner.
- rsp_rdata_o  out  XLEN  read data (shared by both requesters); 0 after a write.
- mem_en_o, mem_we_o  out  1  memory access strobe, write qualifier.
- mem_addr_o  out  AW  word index.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  write data.
- mem_rdata_i  in  XLEN  read data, valid one cycle after mem_en_o.
- busy_o  out  1  high when state ≠ IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → IDLE. No other transitions.
- IDLE: the arbiter combinationally picks a winner among the valid requesters and raises req_ready_o for the winner only. A request is accepted when valid and ready are both high. On acceptance, owner, we, word index, be and wdata are registered and the FSM goes to ISSUE. With no request, the FSM stays in IDLE.
- ISSUE: mem_en_o=1 with the registered fields; then WAIT. req_ready_o=0.
- WAIT: mem_en_o=0. Capture mem_rdata_i (reads) or 0 (writes) into rsp_rdata_o, set rsp_valid_o[owner]=1 at the next edge, then go to IDLE. req_ready_o=0.
- Arbitration: one request alone wins. When both are valid, the winner is chosen per Configuration. last_grant updates only on acceptance.
- Address bits above AW+1 and addr[1:0] are ignored; indices wrap modulo MEM_SIZE.
- Requesters hold valid and their fields stable until ready. Dropping valid before ready is legal and cancels the request.
- Reset, including mid-operation: state=IDLE, the in-flight access is dropped with no response, last_grant=1.
- Reset values: every output 0, including rsp_rdata_o.

## Timing
- Accept edge = cycle 0. mem_en_o is high in cycle 1. mem_rdata_i is sampled at the end of cycle 2. rsp_valid_o/rsp_rdata_o are high/valid in cycle 3 only.
- A new request can be accepted in cycle 3, so sustained throughput is one access per 3 cycles.
- mem_* outputs and rsp_* outputs are registered. req_ready_o and busy_o are combinational from state and inputs.
- No same-cycle path from req_* to mem_*.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On contention, the requester ≠ last_grant wins. Because last_grant resets to 1, requester 0 wins the first contention.
- DMEM_ARB_RR_EN undefined: fixed priority, requester 0 always wins on contention. The last_grant register is absent.

## Structure
- riscv_pkg holds XLEN and MEM_SIZE, plus the new arb_state_e enum (IDLE, ISSUE, WAIT) and the arb_req_t struct {we, addr, wdata, be}.
- One sub-module, dmem_arb_pick: combinational winner selection from valid[1:0] and last_grant, with the macro switch inside it.
- Everything else lives in dmem_arbiter.

## Test plan
- Single read: req0 reads addr 0x10 while the memory holds 0xDEADBEEF at word 4 → mem_addr_o=4 in cycle 1, rsp_valid_o=2'b01 and rsp_rdata_o=0xDEADBEEF in cycle 3, busy_o high in cycles 1–2.
- Byte write: req1 writes 0x000000AB with be=4'b0001 to 0x20 → mem_we_o=1, mem_be_o=4'b0001, mem_addr_o=8 in cycle 1; rsp_valid_o=2'b10 with rsp_rdata_o=0 in cycle 3.
- Contention with DMEM_ARB_RR_EN: both requesters hold valid for 4 accesses → grants 0,1,0,1. Without the macro → grants 0,0,0,0 and req1 is starved until req0 drops.
- Back-to-back: req0 keeps valid high → accepts in cycles 0, 3, 6; mem_en_o high only in cycles 1, 4, 7.
- Reset mid-operation: assert rstn_i=0 during WAIT → all outputs 0 immediately with no rsp_valid_o pulse. After release, the next request completes normally.
- Wrap: req0 reads addr (MEM_SIZE×4)+0x4 → mem_addr_o=1.
